// File: rtl/cover_hit_collector.sv
// cover_hit_collector: sticky coverage bitmap fed by grouped hit vectors.
// Ports: hit_* accept channel, clear/dump starts, out_* dump stream,
// covered_count, new_hit pulse, oor_err sticky flag.
module cover_hit_collector #(
    parameter int COVER_TOTAL = 8744,
    parameter int GROUP_W     = 20,
    parameter int NUM_GROUPS  = (COVER_TOTAL + GROUP_W - 1) / GROUP_W,
    parameter int GI_W        = $clog2(NUM_GROUPS),
    parameter int CNT_W       = $clog2(COVER_TOTAL + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               hit_valid,
    input  logic [GI_W-1:0]    hit_group,
    input  logic [GROUP_W-1:0] hit_bits,
    output logic               hit_ready,
    input  logic               clear_start,
    input  logic               dump_start,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [GI_W-1:0]    out_group,
    output logic [GROUP_W-1:0] out_data,
    output logic               out_last,
    output logic [CNT_W-1:0]   covered_count,
    output logic               new_hit,
    output logic               oor_err
);

    typedef enum logic [1:0] {
        IDLE,
        DUMP,
        CLEAR
    } state_t;

    localparam logic [GI_W-1:0] LAST_G = GI_W'(NUM_GROUPS - 1);

    // bits whose point index lies past COVER_TOTAL never count
    function automatic logic [GROUP_W-1:0] legal_mask(
        input logic [GI_W-1:0] g
    );
        logic [GROUP_W-1:0] m;
        for (int i = 0; i < GROUP_W; i++)
            m[i] = (int'(g) * GROUP_W + i) < COVER_TOTAL;
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(
        input logic [GROUP_W-1:0] v
    );
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < GROUP_W; i++)
            c = c + CNT_W'(v[i]);
        return c;
    endfunction

    state_t             state_q;
    state_t             state_d;
    logic [GROUP_W-1:0] bitmap [NUM_GROUPS];
    logic [GI_W-1:0]    ptr;
    logic [GI_W-1:0]    hit_idx;
    logic [GI_W-1:0]    dump_nxt;
    logic               gi_ok;
    logic               hit_fire;
    logic [GROUP_W-1:0] hit_legal;
    logic [GROUP_W-1:0] hit_new;

    assign hit_ready = (state_q != CLEAR);
    assign hit_fire  = hit_valid && hit_ready;
    assign gi_ok     = (hit_group <= LAST_G);
    assign hit_idx   = gi_ok ? hit_group : '0;
    assign hit_legal = hit_bits & legal_mask(hit_idx);
    // compared against the registered bitmap, which already holds
    // any hit accepted on the previous edge
    assign hit_new   = hit_legal & ~bitmap[hit_idx];
    assign dump_nxt  = out_group + GI_W'(1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (clear_start)
                    state_d = CLEAR;
                else if (dump_start)
                    state_d = DUMP;
            end
            DUMP: begin
                if (out_valid && out_ready && out_last)
                    state_d = IDLE;
            end
            CLEAR: begin
                if (ptr == LAST_G)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_GROUPS; i++)
                bitmap[i] <= '0;
            covered_count <= '0;
            new_hit       <= 1'b0;
            oor_err       <= 1'b0;
            out_valid     <= 1'b0;
            out_group     <= '0;
            out_data      <= '0;
            out_last      <= 1'b0;
            ptr           <= '0;
        end else begin
            new_hit <= 1'b0;
            if (hit_fire && gi_ok) begin
                bitmap[hit_idx] <= bitmap[hit_idx] | hit_legal;
                covered_count   <= covered_count + popcount(hit_new);
                new_hit         <= |hit_new;
            end
            if (hit_fire && !gi_ok)
                oor_err <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (clear_start) begin
                        ptr           <= '0;
                        covered_count <= '0;
                        oor_err       <= 1'b0;
                        new_hit       <= 1'b0;
                    end else if (dump_start) begin
                        out_valid <= 1'b1;
                        out_group <= '0;
                        out_data  <= bitmap[0] & legal_mask('0);
                        out_last  <= (LAST_G == '0);
                    end
                end
                DUMP: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            // next word loads on the accepting edge
                            out_group <= dump_nxt;
                            out_data  <= bitmap[dump_nxt]
                                       & legal_mask(dump_nxt);
                            out_last  <= (dump_nxt == LAST_G);
                        end
                    end
                end
                CLEAR: begin
                    bitmap[ptr] <= '0;
                    ptr         <= ptr + GI_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cover_hit_collector.md
# cover_hit_collector

Synthesizable sink for grouped toggle-coverage hits. It receives one group of hit bits per cycle, for example from a 20-bit toggle cover instance and its group index, and merges them into a sticky coverage bitmap of COVER_TOTAL points. It keeps a running count of distinct covered points. On request it streams the bitmap out group by group over a valid/ready channel, and it can clear the bitmap. It sits at the coverage-collection end of FPGA and formal builds, where DPI reporting is unavailable.

## Interface
- COVER_TOTAL, 8744, number of cover points; point p lives in group p/GROUP_W, bit p%GROUP_W
- GROUP_W, 20, hit bits per group
- NUM_GROUPS, ceil(COVER_TOTAL/GROUP_W) (438), bitmap depth
- GI_W, $clog2(NUM_GROUPS) (9), group index width
- CNT_W, $clog2(COVER_TOTAL+1) (14), counter width
- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- hit_valid  in  1  hit group present this cycle
- hit_group  in  GI_W  group index of hit_bits
- hit_bits  in  GROUP_W  hit vector, bit i is point hit_group*GROUP_W+i
- hit_ready  out  1  hits accepted (0 only in CLEAR)
- clear_start  in  1  pulse: zero bitmap and count
- dump_start  in  1  pulse: stream bitmap out
- out_valid  out  1  dump word valid
- out_ready  in  1  consumer accepts dump word
- out_group  out  GI_W  group index of out_data
- out_data  out  GROUP_W  bitmap word (snapshot)
- out_last  out  1  out word is group NUM_GROUPS-1
- covered_count  out  CNT_W  distinct points covered
- new_hit  out  1  pulse: previous accepted hit set ≥1 new bit
- oor_err  out  1  sticky: hit_group ≥ NUM_GROUPS seen

## Operation
- States: IDLE, DUMP, CLEAR. On reset: IDLE, bitmap all 0, covered_count 0, new_hit 0, oor_err 0, out_valid 0, out_group 0, out_data 0, out_last 0, hit_ready 1.
- Accumulate, in IDLE and DUMP: on hit_valid&&hit_ready with a valid group g:
  - compute m = hit_bits & legal_mask(g) & ~bitmap[g], where legal_mask clears bits ≥ COVER_TOTAL (group 437 keeps bits 3:0 only)
  - bitmap[g] |= hit_bits & legal_mask(g)
  - next cycle: covered_count += popcount(m); new_hit = (m != 0)
- Out-of-range group (≥ NUM_GROUPS): hit dropped, oor_err set until reset or clear.
- Back-to-back hits to the same group are handled. The second hit is evaluated against the bitmap already updated by the first, so no double counting.
- IDLE: clear_start → CLEAR. Otherwise dump_start → DUMP. If both are asserted in the same cycle, clear wins. Start pulses in DUMP or CLEAR are ignored.
- DUMP: pointer starts at 0.
  - Load out_group = ptr, out_data = bitmap[ptr] (masked), out_last = (ptr == NUM_GROUPS-1).
  - On out_valid&&out_ready: increment ptr and load the next word in the same edge (no bubble).
  - After the last word is accepted: out_valid = 0, return to IDLE.
  - A hit landing in a group after its word was loaded does not alter the held out_data. It does update the bitmap.
- CLEAR: hit_ready = 0, hits dropped. On entry, covered_count and oor_err are zeroed. One group is zeroed per cycle, 0..NUM_GROUPS-1. After the last group, return to IDLE.
- covered_count cannot exceed COVER_TOTAL by construction. No saturation logic is required.

## Timing
- Hit accepted in cycle N → bitmap updated at edge N. covered_count and new_hit reflect it in cycle N+1. new_hit is high for one cycle per accepted hit with new bits.
- dump_start in cycle N → out_valid=1, out_group=0 in cycle N+1.
- out_data, out_group and out_last are stable while out_valid && !out_ready.
- Full dump with out_ready held high: NUM_GROUPS consecutive valid cycles (438). out_last is on the final one.
- clear_start in cycle N → hit_ready=0 from N+1 through N+NUM_GROUPS. hit_ready=1 and IDLE at N+NUM_GROUPS+1.
- reset_n low at any time, including mid-dump or mid-clear, forces the reset values immediately. A dump in progress is abandoned, with no out_last.

## Test plan
- Reset, then hit_group=5, hit_bits=0x00003 → covered_count 2 and new_hit 1 one cycle later. Repeat the same hit → new_hit 0, count stays 2.
- Back-to-back hits group 7 with 0x0000F then 0x000FF → count 4 then 8, no double count.
- Hit group 437 with 0xFFFFF → count +4 only. Hit group 500 → dropped, oor_err 1, count unchanged.
- Bitmap groups 0=0x1 and 437=0x8, dump_start with out_ready toggling 1/0 → 438 words in order. Group 0 data 0x1, group 437 data 0x8 with out_last. Data is held during stalls. Return to IDLE.
- A hit to group 10 arrives while word 10 is being presented and stalled → out_data unchanged. A subsequent dump shows the new bits.
- clear_start with dump_start in the same cycle → CLEAR taken, hit_ready low for 438 cycles, hits dropped, count 0. A later dump returns all zeros. Assert reset_n low mid-dump → out_valid 0 immediately.
